branch_predictor: RTL and testbench

Branch prediction unit answering the decode stage's per-branch lookups and learning from branches resolved in execute. Each cycle it looks up the decode-stage PC and branch class, and returns taken/target/entry in the same cycle for the decode stage to forward down the pipe. It holds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters and a speculative return address stack (RAS). The RAS is pushed and popped when decode hands a branch to execute.

---
 rtl/branch_predictor.sv | 160 ++++++++++++++++
 tb/tb_branch_predictor.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Branch predictor: direct-mapped BTB with 2-bit saturating counters and a
// speculative return address stack, combinational lookup for the decode stage.
module branch_predictor #(
  parameter int unsigned BTB_IDX_W = 6,
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [2:0]  ds_br_type,
  input  logic        ds_br_en,
  input  logic [31:0] ds_pc,
  output logic        predict_is_taken,
  output logic [31:0] predict_target,
  output logic [33:0] predict_entry,
  input  logic        es_resolve,
  input  logic [2:0]  es_br_type,
  input  logic [31:0] es_pc,
  input  logic        es_taken,
  input  logic [31:0] es_target,
  input  logic [33:0] es_entry,
  input  logic        es_hit,
  input  logic        flush,
  output logic        predict_hit
);

  localparam int unsigned BTB_N  = 1 << BTB_IDX_W;
  localparam int unsigned TAG_W  = 32 - BTB_IDX_W - 2;
  localparam int unsigned RAS_PW = $clog2(RAS_DEPTH);
  localparam int unsigned RAS_CW = RAS_PW + 1;
  localparam logic [RAS_CW-1:0] RAS_FULL = RAS_CW'(RAS_DEPTH);

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_JUMP = 3'd1,
    BR_CALL = 3'd2,
    BR_RET  = 3'd3,
    BR_COND = 3'd4
  } br_type_e;

  // BTB storage
  logic              btb_valid  [BTB_N];
  logic [TAG_W-1:0]  btb_tag    [BTB_N];
  logic [31:0]       btb_target [BTB_N];
  logic [1:0]        btb_cnt    [BTB_N];

  // RAS storage: ras_ptr names the next free slot, so the top is ras_ptr-1
  logic [31:0]       ras_stack  [RAS_DEPTH];
  logic [RAS_PW-1:0] ras_ptr;
  logic [RAS_CW-1:0] ras_count;

  br_type_e          ds_type;
  br_type_e          es_type;
  logic [BTB_IDX_W-1:0] lk_idx;
  logic [BTB_IDX_W-1:0] es_idx;
  logic              lk_hit;
  logic [31:0]       pc_plus8;
  logic [RAS_PW-1:0] ras_top_ptr;
  logic [31:0]       ras_top;
  logic              ras_push;
  logic              ras_pop;
  logic              es_is_btb;
  logic              btb_train;
  logic              btb_alloc;
  logic [1:0]        es_cnt;
  logic [1:0]        upd_cnt;
  logic              unused_es_bits;

  // Only the counter field of es_entry feeds training; the stored target is kept.
  assign unused_es_bits = ^{es_entry[31:0], es_pc[1:0]};

  assign ds_type     = br_type_e'(ds_br_type);
  assign es_type     = br_type_e'(es_br_type);
  assign lk_idx      = ds_pc[BTB_IDX_W+1:2];
  assign es_idx      = es_pc[BTB_IDX_W+1:2];
  assign pc_plus8    = ds_pc + 32'd8;
  assign ras_top_ptr = ras_ptr - 1'b1;
  assign ras_top     = ras_stack[ras_top_ptr];
  assign lk_hit      = btb_valid[lk_idx] && (btb_tag[lk_idx] == ds_pc[31:BTB_IDX_W+2]);

  always_comb begin
    predict_is_taken = 1'b0;
    predict_target   = pc_plus8;
    predict_entry    = {2'b01, pc_plus8};
    predict_hit      = lk_hit;
    if (lk_hit) begin
      predict_entry = {btb_cnt[lk_idx], btb_target[lk_idx]};
    end
    case (ds_type)
      BR_JUMP, BR_CALL: predict_is_taken = lk_hit;
      BR_COND:          predict_is_taken = lk_hit && btb_cnt[lk_idx][1];
      BR_RET:           predict_is_taken = (ras_count != '0);
      default:          predict_is_taken = 1'b0;
    endcase
    if (predict_is_taken) begin
      predict_target = (ds_type == BR_RET) ? ras_top : btb_target[lk_idx];
    end
  end

  assign ras_push = ds_br_en && (ds_type == BR_CALL);
  assign ras_pop  = ds_br_en && (ds_type == BR_RET) && (ras_count != '0);

  // A full stack keeps wrapping the pointer, overwriting the oldest return address.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ras_ptr   <= '0;
      ras_count <= '0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
        ras_stack[i] <= '0;
      end
    end else if (flush) begin
      ras_ptr   <= '0;
      ras_count <= '0;
    end else if (ras_push) begin
      ras_stack[ras_ptr] <= pc_plus8;
      ras_ptr            <= ras_ptr + 1'b1;
      if (ras_count != RAS_FULL) begin
        ras_count <= ras_count + 1'b1;
      end
    end else if (ras_pop) begin
      ras_ptr   <= ras_ptr - 1'b1;
      ras_count <= ras_count - 1'b1;
    end
  end

  always_comb begin
    es_is_btb = es_resolve &&
                ((es_type == BR_JUMP) || (es_type == BR_CALL) || (es_type == BR_COND));
    btb_train = es_is_btb && es_hit;
    btb_alloc = es_is_btb && !es_hit && es_taken;
    es_cnt    = es_entry[33:32];
    upd_cnt   = es_cnt;
    if (es_taken) begin
      if (es_cnt != 2'b11) upd_cnt = es_cnt + 2'd1;
    end else begin
      if (es_cnt != 2'b00) upd_cnt = es_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < BTB_N; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        btb_cnt[i]    <= 2'b00;
      end
    end else if (btb_train) begin
      btb_cnt[es_idx] <= upd_cnt;
      if (es_taken) begin
        btb_target[es_idx] <= es_target;
      end
    end else if (btb_alloc) begin
      btb_valid[es_idx]  <= 1'b1;
      btb_tag[es_idx]    <= es_pc[31:BTB_IDX_W+2];
      btb_target[es_idx] <= es_target;
      btb_cnt[es_idx]    <= 2'b10;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed plus randomized bench for branch_predictor, checked against a
// behavioural model (per-entry records and a queue-based return stack).
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  ds_br_type;
  logic        ds_br_en;
  logic [31:0] ds_pc;
  logic        predict_is_taken;
  logic [31:0] predict_target;
  logic [33:0] predict_entry;
  logic        es_resolve;
  logic [2:0]  es_br_type;
  logic [31:0] es_pc;
  logic        es_taken;
  logic [31:0] es_target;
  logic [33:0] es_entry;
  logic        es_hit;
  logic        flush;
  logic        predict_hit;

  always #5 clk = ~clk;

  branch_predictor #(.BTB_IDX_W(6), .RAS_DEPTH(8)) dut (
    .clk(clk), .resetn(resetn),
    .ds_br_type(ds_br_type), .ds_br_en(ds_br_en), .ds_pc(ds_pc),
    .predict_is_taken(predict_is_taken), .predict_target(predict_target),
    .predict_entry(predict_entry),
    .es_resolve(es_resolve), .es_br_type(es_br_type), .es_pc(es_pc),
    .es_taken(es_taken), .es_target(es_target), .es_entry(es_entry),
    .es_hit(es_hit), .flush(flush), .predict_hit(predict_hit)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: each slot remembers the full PC that allocated it.
  bit          m_valid [64];
  logic [31:0] m_pc    [64];
  logic [31:0] m_tgt   [64];
  int          m_cnt   [64];
  logic [31:0] ras_q[$];

  logic        e_tk, e_hit;
  logic [31:0] e_tg;
  logic [33:0] e_en;

  task automatic chk(input string name, input logic [33:0] obs, input logic [33:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0; m_pc[i] = '0; m_tgt[i] = '0; m_cnt[i] = 0;
    end
    ras_q.delete();
  endfunction

  function automatic void mpred(input logic [31:0] pc, input logic [2:0] t);
    int idx;
    idx   = int'(pc[7:2]);
    e_hit = m_valid[idx] && (m_pc[idx][31:8] == pc[31:8]);
    e_en  = e_hit ? {2'(m_cnt[idx]), m_tgt[idx]} : {2'b01, pc + 32'd8};
    case (t)
      3'd1, 3'd2: e_tk = e_hit;
      3'd4:       e_tk = e_hit && (m_cnt[idx] >= 2);
      3'd3:       e_tk = (ras_q.size() != 0);
      default:    e_tk = 1'b0;
    endcase
    if (!e_tk)        e_tg = pc + 32'd8;
    else if (t == 3)  e_tg = ras_q[$];
    else              e_tg = m_tgt[idx];
  endfunction

  function automatic void model_update();
    int idx;
    int c;
    if (flush) ras_q.delete();
    else if (ds_br_en && ds_br_type == 3'd2) begin
      ras_q.push_back(ds_pc + 32'd8);
      if (ras_q.size() > 8) void'(ras_q.pop_front());
    end else if (ds_br_en && ds_br_type == 3'd3 && ras_q.size() > 0)
      void'(ras_q.pop_back());
    if (es_resolve && (es_br_type == 3'd1 || es_br_type == 3'd2 || es_br_type == 3'd4)) begin
      idx = int'(es_pc[7:2]);
      if (es_hit) begin
        c = int'(es_entry[33:32]);
        c = es_taken ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
        m_cnt[idx] = c;
        if (es_taken) m_tgt[idx] = es_target;
      end else if (es_taken) begin
        m_valid[idx] = 1'b1; m_pc[idx] = es_pc; m_tgt[idx] = es_target; m_cnt[idx] = 2;
      end
    end
  endfunction

  task automatic look(input string tag);
    #3;
    mpred(ds_pc, ds_br_type);
    chk({tag, ".taken"},  predict_is_taken, e_tk);
    chk({tag, ".target"}, predict_target,   e_tg);
    chk({tag, ".entry"},  predict_entry,    e_en);
    chk({tag, ".hit"},    predict_hit,      e_hit);
  endtask

  task automatic adv();
    @(posedge clk);
    model_update();
    #1;
  endtask

  logic [31:0] pc_pool  [5] = '{32'h80001000, 32'h80001100, 32'h80001004, 32'h80002008, 32'h00400010};
  logic [31:0] tgt_pool [4] = '{32'h80003000, 32'h00400100, 32'h80001000, 32'hBFC00380};
  int          exp_cnt  [4] = '{1, 0, 0, 0};

  initial begin
    logic [31:0] p_pc;
    logic [2:0]  p_type;
    logic        p_hit;
    logic [33:0] p_en;

    resetn = 1'b0; ds_br_type = '0; ds_br_en = 1'b0; ds_pc = '0;
    es_resolve = 1'b0; es_br_type = '0; es_pc = '0; es_taken = 1'b0;
    es_target = '0; es_entry = '0; es_hit = 1'b0; flush = 1'b0;
    model_reset();
    #12 resetn = 1'b1;
    @(posedge clk); #1;

    // Reset state
    ds_pc = 32'hBFC00000; ds_br_type = 3'd4;
    look("reset");
    chk("reset_taken", predict_is_taken, 1'b0);
    chk("reset_target", predict_target, 32'hBFC00008);
    chk("reset_hit", predict_hit, 1'b0);
    adv();

    // Allocate while looking up the same index: old entry visible this cycle
    ds_pc = 32'h80001000; ds_br_type = 3'd4;
    es_resolve = 1'b1; es_br_type = 3'd4; es_pc = 32'h80001000; es_taken = 1'b1;
    es_target = 32'h80002000; es_hit = 1'b0; es_entry = {2'b01, 32'h80001008};
    look("same_idx");
    chk("same_idx_hit", predict_hit, 1'b0);
    adv();
    es_resolve = 1'b0;
    look("alloc");
    chk("alloc_hit", predict_hit, 1'b1);
    chk("alloc_taken", predict_is_taken, 1'b1);
    chk("alloc_target", predict_target, 32'h80002000);
    chk("alloc_cnt", predict_entry[33:32], 2'b10);
    adv();

    // Not-taken training down to and holding at zero
    for (int i = 0; i < 4; i++) begin
      es_resolve = 1'b1; es_br_type = 3'd4; es_pc = 32'h80001000;
      es_taken = 1'b0; es_hit = 1'b1; es_entry = e_en;
      look("train_upd");
      adv();
      es_resolve = 1'b0;
      look("train");
      chk("train_cnt", predict_entry[33:32], 2'(exp_cnt[i]));
      chk("train_taken", predict_is_taken, 1'b0);
      adv();
    end

    // Call / return
    ds_br_en = 1'b1; ds_br_type = 3'd2;
    ds_pc = 32'h100; look("call0"); adv();
    ds_pc = 32'h200; look("call1"); adv();
    ds_br_type = 3'd3; ds_pc = 32'h300;
    look("ret0");
    chk("ret0_taken", predict_is_taken, 1'b1);
    chk("ret0_target", predict_target, 32'h208);
    adv();
    look("ret1");
    chk("ret1_target", predict_target, 32'h108);
    adv();
    look("ret2");
    chk("ret2_taken", predict_is_taken, 1'b0);
    chk("ret2_target", predict_target, 32'h308);
    adv();

    // Overflow: nine pushes into an eight-deep stack
    ds_br_type = 3'd2;
    for (int i = 0; i < 9; i++) begin
      ds_pc = 32'(i * 16); look("ovf_push"); adv();
    end
    ds_br_type = 3'd3; ds_pc = 32'h1000;
    for (int i = 0; i < 9; i++) begin
      look("ovf_pop");
      if (i < 8) chk("ovf_pop_target", predict_target, 32'(32'h88 - i * 16));
      else       chk("ovf_pop_empty", predict_is_taken, 1'b0);
      adv();
    end

    // Flush beats a same-cycle push
    ds_br_type = 3'd2;
    for (int i = 0; i < 3; i++) begin
      ds_pc = 32'(32'h400 + i * 16); look("fl_push"); adv();
    end
    ds_pc = 32'h430; flush = 1'b1;
    look("fl_call"); adv();
    flush = 1'b0; ds_br_type = 3'd3; ds_pc = 32'h500;
    look("fl_ret");
    chk("flush_ret_taken", predict_is_taken, 1'b0);
    adv();
    ds_br_en = 1'b0;

    // Random traffic resolving the previous cycle's lookup
    p_pc = '0; p_type = '0; p_hit = 1'b0; p_en = '0;
    for (int n = 0; n < 600; n++) begin
      ds_pc      = pc_pool[$urandom_range(0, 4)];
      ds_br_type = 3'($urandom_range(0, 4));
      ds_br_en   = 1'($urandom_range(0, 1));
      flush      = ($urandom_range(0, 15) == 0);
      es_resolve = 1'($urandom_range(0, 1));
      es_br_type = p_type; es_pc = p_pc; es_hit = p_hit; es_entry = p_en;
      es_taken   = 1'($urandom_range(0, 1));
      es_target  = tgt_pool[$urandom_range(0, 3)];
      look("rand");
      p_pc = ds_pc; p_type = ds_br_type; p_hit = e_hit; p_en = e_en;
      adv();
    end
    ds_br_en = 1'b0; flush = 1'b0; es_resolve = 1'b0;

    // Asynchronous reset in the middle of an allocating cycle
    ds_pc = 32'h80004000; ds_br_type = 3'd1;
    es_resolve = 1'b1; es_br_type = 3'd1; es_pc = 32'h80004000; es_taken = 1'b1;
    es_target = 32'h80005000; es_hit = 1'b0; es_entry = {2'b01, 32'h80004008};
    look("pre_rst"); adv();
    es_pc = 32'h80006000; es_target = 32'h80007000;
    look("pre_rst_hit");
    chk("pre_rst_hit1", predict_hit, 1'b1);
    resetn = 1'b0;
    #1;
    model_reset();
    chk("arst_hit", predict_hit, 1'b0);
    chk("arst_taken", predict_is_taken, 1'b0);
    chk("arst_target", predict_target, 32'h80004008);
    @(posedge clk); #2;
    resetn = 1'b1;
    es_resolve = 1'b0; ds_pc = 32'h80006000;
    look("post_rst");
    chk("post_rst_hit", predict_hit, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
